// File: rtl/qsq_pkg.sv
// Shared types, widths and helpers for the quarter-square multiplier sequencer.
package qsq_pkg;

    localparam int OP_W   = 7;
    localparam int LUT_AW = OP_W + 1;
    localparam int LUT_DW = 16;
    localparam int PROD_W = 2 * OP_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUM  = 3'd1,
        DIFF = 3'd2,
        SUBT = 3'd3,
        DONE = 3'd4
    } state_t;

    // Magnitude of the operand difference: larger minus smaller, never wraps.
    function automatic logic [OP_W-1:0] abs_diff(input logic [OP_W-1:0] a,
                                                 input logic [OP_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/qsq_mult_ctrl.sv
// Quarter-square multiplier sequencer: a*b = Q(a+b) - Q(|a-b|), Q(x)=floor(x^2/4).
// One external registered Q table is time-shared: sum lookup, diff lookup, subtract.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready depends only on state (high in IDLE); out_valid depends only on
// state (high in DONE) and holds with out_prod stable until out_ready is seen.
// Neither ready nor valid is combinationally derived from the opposite side.
module qsq_mult_ctrl
    import qsq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_prod,
    output logic [LUT_AW-1:0] lut_addr,
    input  logic [LUT_DW-1:0] lut_data,
    output logic              busy,
    output state_t            o_dbg_state
);

    state_t              r_state;
    state_t              w_next;
    logic [OP_W-1:0]     r_a;
    logic [OP_W-1:0]     r_b;
    logic [LUT_DW-1:0]   r_sq_sum;
    logic [PROD_W-1:0]   r_prod;
    logic                w_accept;
    logic                w_cap_sum;
    logic                w_cap_prod;
    logic [PROD_W-1:0]   w_prod;

    // Q(a+b) >= Q(|a-b|) and the difference is a*b < 2^14, so truncation is exact.
    assign w_prod = PROD_W'(r_sq_sum - lut_data);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, handshake outputs, table address and datapath load enables.
    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        lut_addr   = '0;
        w_accept   = 1'b0;
        w_cap_sum  = 1'b0;
        w_cap_prod = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = SUM;
                end
            end
            SUM: begin
                lut_addr = LUT_AW'(r_a) + LUT_AW'(r_b);
                w_next   = DIFF;
            end
            DIFF: begin
                lut_addr  = LUT_AW'(abs_diff(r_a, r_b));
                w_cap_sum = 1'b1;
                w_next    = SUBT;
            end
            SUBT: begin
                w_cap_prod = 1'b1;
                w_next     = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand latches, Q(a+b) holding register and product register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sq_sum <= '0;
            r_prod   <= '0;
        end else begin
            if (w_accept) begin
                r_a <= in_a;
                r_b <= in_b;
            end
            if (w_cap_sum) begin
                r_sq_sum <= lut_data;
            end
            if (w_cap_prod) begin
                r_prod <= w_prod;
            end
        end
    end

    assign out_prod    = r_prod;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_qsq_mult_ctrl.sv
// Bench for qsq_mult_ctrl with a registered true-Q table and an a*b golden model.
module tb_qsq_mult_ctrl;
  import qsq_pkg::*;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_a;
  logic [OP_W-1:0]   in_b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] out_prod;
  logic [LUT_AW-1:0] lut_addr;
  logic [LUT_DW-1:0] lut_data = '0;
  logic              busy;
  state_t            dbg_state;

  always #5 clk = ~clk;

  qsq_mult_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prod   (out_prod),
    .lut_addr   (lut_addr),
    .lut_data   (lut_data),
    .busy       (busy),
    .o_dbg_state(dbg_state)
  );

  // Registered Q table holding true floor(x^2/4) values.
  function automatic logic [LUT_DW-1:0] q_of(input int x);
    return LUT_DW'((x * x) / 4);
  endfunction

  always @(posedge clk) lut_data <= q_of(int'(lut_addr));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [PROD_W-1:0] exp_q[$];
  bit sweep_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor used by the back-to-back sweep.
  always @(negedge clk) begin
    if (sweep_on && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sweep_unexpected_output: got %0d expected none", out_prod);
      end else begin
        check("sweep_prod", 32'(out_prod), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic [PROD_W-1:0] prod;
    logic [LUT_AW-1:0] sum_addr;
    logic [LUT_AW-1:0] diff_addr;
  } vec_t;

  vec_t vecs[11];

  // ---------------- driver tasks ----------------
  // Starts and ends at a negedge with the DUT in IDLE.
  task automatic do_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                       input logic [PROD_W-1:0] exp_prod,
                       input logic [LUT_AW-1:0] exp_sum, input logic [LUT_AW-1:0] exp_diff);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = OP_W'($urandom_range(0, 127));
    in_b     = OP_W'($urandom_range(0, 127));
    check("sum_addr", 32'(lut_addr), 32'(exp_sum));
    check("in_ready_busy", 32'(in_ready), 32'd0);
    check("busy_sum", 32'(busy), 32'd1);
    @(negedge clk);
    check("diff_addr", 32'(lut_addr), 32'(exp_diff));
    @(negedge clk);
    check("no_early_valid", 32'(out_valid), 32'd0);
    check("subt_addr", 32'(lut_addr), 32'd0);
    @(negedge clk);
    check("valid_latency4", 32'(out_valid), 32'd1);
    check("prod", 32'(out_prod), 32'(exp_prod));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("ready_return", 32'(in_ready), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int accepted;
    int budget;
    bit stale;

    vecs[0]  = '{a: 7'd5,   b: 7'd3,   prod: 14'd15,    sum_addr: 8'd8,   diff_addr: 8'd2};
    vecs[1]  = '{a: 7'd127, b: 7'd127, prod: 14'd16129, sum_addr: 8'd254, diff_addr: 8'd0};
    vecs[2]  = '{a: 7'd127, b: 7'd102, prod: 14'd12954, sum_addr: 8'd229, diff_addr: 8'd25};
    vecs[3]  = '{a: 7'd0,   b: 7'd77,  prod: 14'd0,     sum_addr: 8'd77,  diff_addr: 8'd77};
    vecs[4]  = '{a: 7'd77,  b: 7'd0,   prod: 14'd0,     sum_addr: 8'd77,  diff_addr: 8'd77};
    vecs[5]  = '{a: 7'd6,   b: 7'd3,   prod: 14'd18,    sum_addr: 8'd9,   diff_addr: 8'd3};
    vecs[6]  = '{a: 7'd1,   b: 7'd1,   prod: 14'd1,     sum_addr: 8'd2,   diff_addr: 8'd0};
    vecs[7]  = '{a: 7'd0,   b: 7'd0,   prod: 14'd0,     sum_addr: 8'd0,   diff_addr: 8'd0};
    vecs[8]  = '{a: 7'd127, b: 7'd0,   prod: 14'd0,     sum_addr: 8'd127, diff_addr: 8'd127};
    vecs[9]  = '{a: 7'd100, b: 7'd27,  prod: 14'd2700,  sum_addr: 8'd127, diff_addr: 8'd73};
    vecs[10] = '{a: 7'd1,   b: 7'd127, prod: 14'd127,   sum_addr: 8'd128, diff_addr: 8'd126};

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_prod", 32'(out_prod), 32'd0);
    check("rst_lut_addr", 32'(lut_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].sum_addr, vecs[i].diff_addr);
    end

    // Backpressure with a pending next request.
    in_valid = 1'b1;
    in_a = 7'd10;
    in_b = 7'd11;
    @(negedge clk);
    in_a = 7'd3;
    in_b = 7'd4;
    check("bp_sum_addr", 32'(lut_addr), 32'd21);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_prod_stable", 32'(out_prod), 32'd110);
      check("bp_no_accept", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_ready_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_sum_addr", 32'(lut_addr), 32'd7);
    @(negedge clk);
    check("bp_next_diff_addr", 32'(lut_addr), 32'd1);
    repeat (2) @(negedge clk);
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_prod", 32'(out_prod), 32'd12);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_next_idle", 32'(in_ready), 32'd1);

    // Reset asserted while in DIFF.
    in_valid = 1'b1;
    in_a = 7'd50;
    in_b = 7'd20;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_diff_addr", 32'(lut_addr), 32'd30);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_addr", 32'(lut_addr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("no_stale_result", 32'(stale), 32'd0);
    do_op(7'd9, 7'd9, 14'd81, 8'd18, 8'd0);

    // Back-to-back random sweep against the a*b golden model.
    sweep_on  = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 7'd127;
    in_b      = 7'd126;
    accepted  = 0;
    budget    = 0;
    while (accepted < 2500 && budget < 20000) begin
      if (in_ready) begin
        exp_q.push_back(PROD_W'(in_a) * PROD_W'(in_b));
        accepted++;
      end else begin
        in_a = OP_W'($urandom_range(0, 127));
        in_b = OP_W'($urandom_range(0, 127));
      end
      @(negedge clk);
      budget++;
    end
    in_valid = 1'b0;
    check("sweep_accepted", 32'(accepted), 32'd2500);
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("sweep_drained", 32'(exp_q.size()), 32'd0);
    sweep_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
